// File: rtl/cordic_shift_sched.sv
// rtl/cordic_shift_sched.sv - CORDIC x/y scaling scheduler sharing one FP right-shift unit
// Each iteration: fetch x/y, shift x then y through the shared unit, present the pair.
module cordic_shift_sched #(
  parameter int MAX_ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  n_iter,
  input  logic [31:0] x_cur,
  input  logic [31:0] y_cur,
  input  logic        cur_valid,
  output logic [31:0] sh_val,
  output logic [3:0]  sh_amt,
  input  logic [31:0] sh_res,
  output logic [31:0] xs,
  output logic [31:0] ys,
  output logic [3:0]  iter,
  output logic        step_valid,
  input  logic        step_ack,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SHX     = 3'd2,
    SHY     = 3'd3,
    PRESENT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [4:0] MAX_N = 5'(MAX_ITER);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  n_lat;
  logic [31:0] x_lat;
  logic [31:0] y_lat;
  logic [4:0]  n_clamp;
  logic        last_iter;

  assign n_clamp   = (n_iter > MAX_N) ? MAX_N : n_iter;
  // n_lat is never 0 outside IDLE/DONE, so the subtraction cannot underflow when it matters
  assign last_iter = ({1'b0, iter} == (n_lat - 5'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_clamp == 5'd0) ? DONE : FETCH;
      FETCH:   if (cur_valid) state_nxt = SHX;
      SHX:     state_nxt = SHY;
      SHY:     state_nxt = PRESENT;
      PRESENT: if (step_ack) state_nxt = last_iter ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat <= 5'd0;
      iter  <= 4'd0;
      x_lat <= 32'd0;
      y_lat <= 32'd0;
      xs    <= 32'd0;
      ys    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat <= n_clamp;
            iter  <= 4'd0;
          end
        end
        FETCH: begin
          if (cur_valid) begin
            x_lat <= x_cur;
            y_lat <= y_cur;
          end
        end
        SHX:     xs <= sh_res;
        SHY:     ys <= sh_res;
        PRESENT: if (step_ack && !last_iter) iter <= iter + 4'd1;
        default: ;
      endcase
    end
  end

  // Shared shifter sees zero operands whenever this block is not using it
  always_comb begin
    sh_val     = 32'd0;
    sh_amt     = 4'd0;
    step_valid = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      SHX: begin
        sh_val = x_lat;
        sh_amt = iter;
      end
      SHY: begin
        sh_val = y_lat;
        sh_amt = iter;
      end
      PRESENT: step_valid = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_shift_sched.sv
// tb/tb_cordic_shift_sched.sv - directed self-checking bench for cordic_shift_sched
// A behavioural FP right-shift model stands in for the shared unit.
module tb_cordic_shift_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  n_iter;
  logic [31:0] x_cur;
  logic [31:0] y_cur;
  logic        cur_valid;
  logic [31:0] sh_val;
  logic [3:0]  sh_amt;
  logic [31:0] sh_res;
  logic [31:0] xs;
  logic [31:0] ys;
  logic [3:0]  iter;
  logic        step_valid;
  logic        step_ack;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  logic [31:0] sx [0:31];
  logic [31:0] sy [0:31];
  logic [3:0]  si [0:31];

  cordic_shift_sched #(.MAX_ITER(16)) dut (
    .clk(clk), .rst(rst), .start(start), .n_iter(n_iter),
    .x_cur(x_cur), .y_cur(y_cur), .cur_valid(cur_valid),
    .sh_val(sh_val), .sh_amt(sh_amt), .sh_res(sh_res),
    .xs(xs), .ys(ys), .iter(iter), .step_valid(step_valid),
    .step_ack(step_ack), .busy(busy), .done(done)
  );

  function automatic logic [31:0] fp_shr(input logic [31:0] v, input logic [3:0] a);
    if (v[30:23] <= {4'd0, a}) return 32'd0;
    return {v[31], v[30:23] - {4'd0, a}, v[22:0]};
  endfunction

  assign sh_res = fp_shr(sh_val, sh_amt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [4:0] n, input logic [31:0] x, input logic [31:0] y,
                     output int cyc, output int steps);
    bit got;
    @(negedge clk);
    start = 1'b1; n_iter = n; x_cur = x; y_cur = y; cur_valid = 1'b1; step_ack = 1'b1;
    cyc = 0; steps = 0; got = 1'b0;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (step_valid && steps < 32) begin
        sx[steps] = xs; sy[steps] = ys; si[steps] = iter;
        steps++;
      end
      if (done) got = 1'b1;
    end
    check("run_done_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_step(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (step_valid) ok = 1'b1;
    end
    check("wait_step_timeout", 32'(ok), 32'd1);
  endtask

  task automatic ack_pulse();
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
  endtask

  initial begin
    int cyc;
    int steps;
    bit ok;
    bit done_seen;
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; n_iter = 5'd0; x_cur = 32'd0; y_cur = 32'd0;
    cur_valid = 1'b0; step_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_step_valid", {31'd0, step_valid}, 32'd0);
    check("rst_xs", xs, 32'd0);
    check("rst_ys", ys, 32'd0);
    check("rst_iter", {28'd0, iter}, 32'd0);
    check("rst_sh_val", sh_val, 32'd0);
    check("rst_sh_amt", {28'd0, sh_amt}, 32'd0);
    rst = 1'b0;

    // N=3, x=1.0, y=2.0
    run(5'd3, 32'h3F800000, 32'h40000000, cyc, steps);
    check("n3_cycles", 32'(cyc), 32'd13);
    check("n3_steps", 32'(steps), 32'd3);
    check("n3_xs0", sx[0], 32'h3F800000);
    check("n3_xs1", sx[1], 32'h3F000000);
    check("n3_xs2", sx[2], 32'h3E800000);
    check("n3_ys0", sy[0], 32'h40000000);
    check("n3_ys1", sy[1], 32'h3F800000);
    check("n3_ys2", sy[2], 32'h3F000000);
    check("n3_iter2", {28'd0, si[2]}, 32'd2);
    check("n3_xs_retained", xs, 32'h3E800000);

    // signed zero flushes to +0
    run(5'd1, 32'h80000000, 32'h00000000, cyc, steps);
    check("negzero_xs", sx[0], 32'h00000000);
    check("zero_ys", sy[0], 32'h00000000);

    // exponent not above shift amount underflows to 0
    run(5'd2, 32'h00800000, 32'h3F800000, cyc, steps);
    check("small_xs0", sx[0], 32'h00800000);
    check("small_xs1", sx[1], 32'h00000000);
    check("small_ys1", sy[1], 32'h3F000000);

    run(5'd0, 32'h3F800000, 32'h40000000, cyc, steps);
    check("n0_cycles", 32'(cyc), 32'd1);
    check("n0_steps", 32'(steps), 32'd0);

    // clamp to MAX_ITER
    run(5'd20, 32'h3F800000, 32'h40000000, cyc, steps);
    check("n20_steps", 32'(steps), 32'd16);
    check("n20_cycles", 32'(cyc), 32'd65);
    check("n20_last_iter", {28'd0, si[15]}, 32'd15);
    check("n20_last_xs", sx[15], 32'h38000000);
    check("n20_last_ys", sy[15], 32'h38800000);

    // stalls: cur_valid low 3 cycles at iter 1, then step_ack held off 5 cycles
    @(negedge clk);
    start = 1'b1; n_iter = 5'd2; x_cur = 32'h40800000; y_cur = 32'h3F800000;
    cur_valid = 1'b1; step_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_step(ok);
    cur_valid = 1'b0;
    ack_pulse();
    for (int i = 0; i < 3; i++) begin
      check("fetch_wait_step_valid", {31'd0, step_valid}, 32'd0);
      check("fetch_wait_sh_amt", {28'd0, sh_amt}, 32'd0);
      check("fetch_wait_iter", {28'd0, iter}, 32'd1);
      if (i < 2) @(negedge clk);
    end
    cur_valid = 1'b1;
    wait_step(ok);
    for (int i = 0; i < 5; i++) begin
      check("hold_step_valid", {31'd0, step_valid}, 32'd1);
      check("hold_xs", xs, 32'h40000000);
      check("hold_ys", ys, 32'h3F000000);
      check("hold_iter", {28'd0, iter}, 32'd1);
      check("hold_sh_amt", {28'd0, sh_amt}, 32'd0);
      @(negedge clk);
    end
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    check("stall_done", {31'd0, done}, 32'd1);

    // start while busy ignored, then reset in PRESENT at iter 2
    @(negedge clk);
    start = 1'b1; n_iter = 5'd5; x_cur = 32'h3F800000; y_cur = 32'h40000000;
    cur_valid = 1'b1; step_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_step(ok);
    start = 1'b1; n_iter = 5'd1;
    ack_pulse();
    start = 1'b0;
    wait_step(ok);
    ack_pulse();
    wait_step(ok);
    check("busy_start_iter", {28'd0, iter}, 32'd2);
    check("busy_start_ys", ys, 32'h3F000000);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_step_valid", {31'd0, step_valid}, 32'd0);
    check("abort_xs", xs, 32'd0);
    check("abort_ys", ys, 32'd0);
    check("abort_iter", {28'd0, iter}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_shift_sched.md
CORDIC_SHIFT_SCHED -- requirements
Module: cordic_shift_sched

Interface
REQ-001 SHALL have parameter MAX_ITER, default 16, meaning the upper clamp on the iteration count (legal 1..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  starts a run when sampled high in IDLE.
REQ-005 SHALL have port n_iter  input  5  iteration count, latched on accepted start.
REQ-006 SHALL have port x_cur  input  32  current CORDIC x, IEEE-754 single.
REQ-007 SHALL have port y_cur  input  32  current CORDIC y, IEEE-754 single.
REQ-008 SHALL have port cur_valid  input  1  x_cur/y_cur valid for the current iteration.
REQ-009 SHALL have port sh_val  output  32  operand to the shared FP right-shift unit.
REQ-010 SHALL have port sh_amt  output  4  shift amount to the shared unit.
REQ-011 SHALL have port sh_res  input  32  combinational result of the shared unit.
REQ-012 SHALL have port xs  output  32  registered x*2^-iter.
REQ-013 SHALL have port ys  output  32  registered y*2^-iter.
REQ-014 SHALL have port iter  output  4  current iteration index.
REQ-015 SHALL have port step_valid  output  1  xs/ys/iter valid for the datapath.
REQ-016 SHALL have port step_ack  input  1  datapath has consumed the step.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-019 SHALL implement states IDLE, FETCH, SHX, SHY, PRESENT, DONE.
REQ-020 IDLE: on start, SHALL latch N = min(n_iter, MAX_ITER), clear iter to 0, and go to FETCH; if N == 0, SHALL go to DONE instead.
REQ-021 start SHALL be ignored outside IDLE; n_iter changes after acceptance SHALL have no effect.
REQ-022 FETCH: SHALL wait while cur_valid is low; when cur_valid is high, SHALL latch x_cur/y_cur into internal registers and go to SHX.
REQ-023 SHX: SHALL drive sh_val = latched x and sh_amt = iter, capture sh_res into xs at the clock edge, and go to SHY.
REQ-024 SHY: SHALL drive sh_val = latched y and sh_amt = iter, capture sh_res into ys, and go to PRESENT.
REQ-025 Outside SHX/SHY, sh_val and sh_amt SHALL be 0 (shared unit idle, output 0).
REQ-026 PRESENT: step_valid SHALL be 1 and xs/ys/iter SHALL be held stable until step_ack.
REQ-027 On step_ack in PRESENT: if iter == N-1, SHALL go to DONE; otherwise SHALL increment iter and go to FETCH.
REQ-028 step_ack outside PRESENT SHALL be ignored.
REQ-029 DONE: done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE; xs/ys/iter SHALL retain their last values.
REQ-030 Minimum per-iteration latency SHALL be 4 cycles (FETCH, SHX, SHY, PRESENT) with cur_valid and step_ack tied high; full run = 4N+1 cycles from start acceptance to done.
REQ-031 iter SHALL never exceed 15; there SHALL be no wrap-around because N <= 16.
REQ-032 No arithmetic on sh_res SHALL be performed; xs/ys are bit-exact copies of sh_res.

Reset
REQ-033 rst SHALL force IDLE, iter=0, N=0, xs=0, ys=0, sh_val=0, sh_amt=0, step_valid=0, busy=0, done=0.
REQ-034 rst asserted mid-run SHALL abort the run with no done pulse; rst SHALL take priority over start in the same cycle.

Verification
REQ-035 Setup: x_cur=0x3F800000 (1.0), y_cur=0x40000000 (2.0), N=3, acks tied high -> steps show xs=0x3F800000/0x3F000000/0x3E800000 and ys=0x40000000/0x3F800000/0x3F000000, with done 13 cycles after start.
REQ-036 Setup: x_cur=0x00000000 or 0x80000000, any iter -> xs=0x00000000.
REQ-037 Setup: x_cur=0x00800000 at iter=1 (exponent <= shift) -> xs=0x00000000.
REQ-038 Setup: n_iter=0 -> done after 1 cycle with no step_valid; n_iter=20 -> exactly 16 steps, last iter=15.
REQ-039 Setup: cur_valid low for 3 cycles and step_ack delayed 5 cycles -> state held, xs/ys/iter stable, sh_amt=0 while waiting.
REQ-040 Setup: rst in PRESENT at iter=2, and start asserted while busy -> rst gives outputs at reset values with no done; the busy start is ignored and iter is unchanged.
